adder_resp_misr: RTL and testbench
==================================

Name: adder_resp_misr

Overview:
- Response compactor placed directly downstream of the gate-level adder under fault simulation.
- Each cycle it accepts a qualified response word {s, c} and folds it into a multiple-input signature register (MISR). It runs for a programmed number of patterns.
- At the end it compares the final signature with an expected golden value and reports pass/fail. This lets the fault flow grade faults by signature instead of by per-pattern compare.

Parameters:
- W, 5, response width in bits (sum bits plus carry-out, packed {s, c}).
- POLY, 5'b00101, feedback taps: bit i set means sig[W-1] is XORed into bit i.
- SEED, 5'b00000, signature value loaded on start.
- NPAT, 256, number of valid responses compacted per run (must be at least 1).
- CW, $clog2(NPAT+1), width of the pattern counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
- resp_valid  input  1  resp_data is a valid adder response this cycle.
- resp_data  input  W  adder response {s[3:0], c}.
- exp_sig  input  W  golden signature; sampled at the transition into DONE.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- pass  output  1  signature == exp_sig; meaningful only while done=1.
- signature  output  W  current MISR contents.
- pat_cnt  output  CW  number of responses compacted in the current or last run.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge), overriding every other input:
  - state=IDLE
  - signature=SEED, pat_cnt=0
  - busy=0, done=0, pass=0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Outputs hold.
  - start=1 -> RUN next cycle; signature<=SEED, pat_cnt<=0, pass<=0.
  - resp_valid is ignored.
- RUN (busy=1):
  - resp_valid=1 -> signature<=misr(signature, resp_data) and pat_cnt<=pat_cnt+1.
  - resp_valid=0 -> all state holds; gaps of any length are legal.
  - Valid response with pat_cnt==NPAT-1:
    - the update is applied;
    - state<=DONE;
    - pass<=(updated signature == exp_sig), with exp_sig sampled at this same edge.
  - start during RUN is ignored. A run cannot be restarted mid-flight except by reset.
- DONE (done=1):
  - signature, pat_cnt and pass hold.
  - resp_valid is ignored.
  - start=1 -> RUN with the same initialisation as from IDLE; done drops the next cycle.
- MISR update, for i in 0..W-1:
  - next[i] = (i>0 ? sig[i-1] : 0) ^ (POLY[i] & sig[W-1]) ^ d[i].
  - Purely linear: any single-bit error in any one response must give a signature different from fault-free.
- Latency:
  - Signature reflects a response one cycle after its valid edge.
  - done and pass are valid in the cycle after the NPAT-th valid response.
- pat_cnt never exceeds NPAT and never wraps.
- All outputs are registered; no combinational path from inputs to outputs.
- start and resp_valid in the same IDLE cycle: start is honoured and that response is dropped.

Test Plan:
- Reset sequence with rst_n low for 2 cycles during RUN -> next cycle state=IDLE, signature=5'b00000, pat_cnt=0, busy=0, done=0, pass=0.
- NPAT=3, start, then valid data 5'b00001, 5'b10000, 5'b00000 on consecutive cycles:
  - signature goes 00001, then 10010, then 00001;
  - done=1 the cycle after the third response;
  - exp_sig=5'b00001 -> pass=1; exp_sig=5'b00010 -> pass=0.
- Same NPAT=3 stream with resp_valid low for 4 cycles between each response -> identical final signature 5'b00001 and pat_cnt=3; busy stays high throughout the gaps.
- NPAT=256, exhaustive {a,b}=0..255 driven into a fault-free adder -> golden signature G captured. Rerun with a stuck-at-0 on c -> signature != G, and pass=0 with exp_sig=G.
- start pulsed mid-RUN after 1 of 3 responses -> no effect; run completes after 3 total responses. Then start in DONE -> busy=1, done=0, signature=SEED, pat_cnt=0 on the next cycle.
- In DONE, resp_valid=1 with random data for 10 cycles -> signature, pat_cnt and pass unchanged.

Source files
------------

// File: rtl/adder_resp_if.sv
// Bus between the fault-simulation stimulus side and the adder response MISR:
// the response stream, run control and the signature/verdict status.
interface adder_resp_if #(
  parameter int W  = 5,
  parameter int CW = 9
);
  logic          start;
  logic          resp_valid;
  logic [W-1:0]  resp_data;
  logic [W-1:0]  exp_sig;
  logic          busy;
  logic          done;
  logic          pass;
  logic [W-1:0]  signature;
  logic [CW-1:0] pat_cnt;

  modport master (
    output start, resp_valid, resp_data, exp_sig,
    input  busy, done, pass, signature, pat_cnt
  );

  modport slave (
    input  start, resp_valid, resp_data, exp_sig,
    output busy, done, pass, signature, pat_cnt
  );
endinterface

// File: rtl/adder_resp_misr.sv
// Compacts NPAT qualified adder responses into a MISR signature and compares
// the final signature against a golden value to give a pass/fail verdict.
module adder_resp_misr #(
  parameter int           W    = 5,
  parameter logic [W-1:0] POLY = 5'b00101,
  parameter logic [W-1:0] SEED = 5'b00000,
  parameter int           NPAT = 256,
  parameter int           CW   = $clog2(NPAT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  adder_resp_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  sig_q,   sig_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          pass_q,  pass_d;
  logic [W-1:0]  sig_upd;

  // Shift toward the MSB; the bit shifted out feeds back through the taps.
  function automatic logic [W-1:0] misr_next(input logic [W-1:0] sig,
                                             input logic [W-1:0] d);
    misr_next = {sig[W-2:0], 1'b0} ^ (POLY & {W{sig[W-1]}}) ^ d;
  endfunction

  assign sig_upd = misr_next(sig_q, bus.resp_data);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.resp_valid) begin
          sig_d = sig_upd;
          cnt_d = cnt_q + CW'(1);
          // Last response: the verdict uses the signature including this word.
          if (cnt_q == CW'(NPAT - 1)) begin
            state_d = ST_DONE;
            pass_d  = (sig_upd == bus.exp_sig);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so all update together.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  // Status outputs decode flops only, so no input reaches an output directly.
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;
  assign bus.pat_cnt   = cnt_q;

endmodule

// File: tb/tb_adder_resp_misr.sv
// Self-checking bench: a short-run (NPAT=3) and a full-run (NPAT=256) MISR
// checked every cycle against a behavioural model, plus directed literals.
module tb_adder_resp_misr;

  localparam logic [4:0] SEED = 5'b00000;
  localparam int         POLY = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_resp_if #(.W(5), .CW(2)) bus_s ();
  adder_resp_if #(.W(5), .CW(9)) bus_b ();

  adder_resp_misr #(.W(5), .POLY(5'b00101), .SEED(SEED), .NPAT(3)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));
  adder_resp_misr #(.W(5), .POLY(5'b00101), .SEED(SEED), .NPAT(256)) u_big (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Index 0 drives/observes the NPAT=3 instance, index 1 the NPAT=256 one.
  logic       start_v [2];
  logic       valid_v [2];
  logic [4:0] data_v  [2];
  logic [4:0] exp_v   [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       pass_v  [2];
  logic [4:0] sig_v   [2];
  int         cnt_v   [2];
  int         npat    [2] = '{3, 256};

  assign bus_s.start = start_v[0];  assign bus_s.resp_valid = valid_v[0];
  assign bus_s.resp_data = data_v[0];  assign bus_s.exp_sig = exp_v[0];
  assign bus_b.start = start_v[1];  assign bus_b.resp_valid = valid_v[1];
  assign bus_b.resp_data = data_v[1];  assign bus_b.exp_sig = exp_v[1];
  assign busy_v[0] = bus_s.busy;  assign done_v[0] = bus_s.done;
  assign pass_v[0] = bus_s.pass;  assign sig_v[0]  = bus_s.signature;
  assign cnt_v[0]  = int'(bus_s.pat_cnt);
  assign busy_v[1] = bus_b.busy;  assign done_v[1] = bus_b.done;
  assign pass_v[1] = bus_b.pass;  assign sig_v[1]  = bus_b.signature;
  assign cnt_v[1]  = int'(bus_b.pat_cnt);

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int k, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Signature arithmetic: multiply by x modulo x^5+x^2+1, then add the word.
  function automatic logic [4:0] fold(input logic [4:0] s, input logic [4:0] d);
    int v;
    v = int'(s) * 2;
    if (v >= 32) v = v ^ 32 ^ POLY;
    v = v ^ int'(d);
    return v[4:0];
  endfunction

  // Response of a 4-bit adder for pattern t = {a,b}, optionally with carry stuck at 0.
  function automatic logic [4:0] adder_resp(input int t, input bit stuck_c);
    int a, b, s;
    logic c;
    a = (t >> 4) & 15;
    b = t & 15;
    s = a + b;
    c = stuck_c ? 1'b0 : s[4];
    return {s[3:0], c};
  endfunction

  // Behavioural model of one run: phase, signature, responses taken, verdict.
  typedef enum int {M_IDLE, M_RUN, M_DONE} phase_e;
  phase_e     m_ph   [2];
  logic [4:0] m_sig  [2];
  int         m_cnt  [2];
  logic       m_pass [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ph[k] = M_IDLE; m_sig[k] = SEED; m_cnt[k] = 0; m_pass[k] = 1'b0;
      end else if (m_ph[k] != M_RUN) begin
        if (start_v[k]) begin
          m_ph[k] = M_RUN; m_sig[k] = SEED; m_cnt[k] = 0; m_pass[k] = 1'b0;
        end
      end else if (valid_v[k]) begin
        m_sig[k] = fold(m_sig[k], data_v[k]);
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == npat[k]) begin
          m_ph[k]   = M_DONE;
          m_pass[k] = (m_sig[k] == exp_v[k]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("busy", k, int'(busy_v[k]), int'(m_ph[k] == M_RUN));
        check("done", k, int'(done_v[k]), int'(m_ph[k] == M_DONE));
        check("pass", k, int'(pass_v[k]), int'(m_pass[k]));
        check("signature", k, int'(sig_v[k]), int'(m_sig[k]));
        check("pat_cnt", k, cnt_v[k], m_cnt[k]);
      end
    end
  end

  // One clock: inputs set at the negedge are taken at the posedge, and outputs
  // are observed at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int k, input logic [4:0] d);
    valid_v[k] = 1'b1;
    data_v[k]  = d;
    step();
    valid_v[k] = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    start_v[k] = 1'b1;
    step();
    start_v[k] = 1'b0;
  endtask

  // Drives all 256 adder patterns into the big instance with random gaps.
  task automatic run_exhaustive(input bit stuck_c);
    pulse_start(1);
    for (int t = 0; t < 256; t++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      send(1, adder_resp(t, stuck_c));
    end
  endtask

  logic [4:0] g, gf, rexp;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0; valid_v[k] = 1'b0; data_v[k] = '0; exp_v[k] = '0;
    end
    step(); step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset asserted for two cycles in the middle of a run.
    pulse_start(0);
    send(0, 5'b00001);
    check("lit_busy_run", 0, int'(busy_v[0]), 1);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("lit_rst_busy", 0, int'(busy_v[0]), 0);
    check("lit_rst_done", 0, int'(done_v[0]), 0);
    check("lit_rst_pass", 0, int'(pass_v[0]), 0);
    check("lit_rst_sig", 0, int'(sig_v[0]), 0);
    check("lit_rst_cnt", 0, cnt_v[0], 0);

    // start and a response in the same IDLE cycle: the response is dropped.
    start_v[0] = 1'b1; valid_v[0] = 1'b1; data_v[0] = 5'b10101;
    step();
    start_v[0] = 1'b0; valid_v[0] = 1'b0;
    check("lit_drop_sig", 0, int'(sig_v[0]), 0);
    check("lit_drop_cnt", 0, cnt_v[0], 0);

    // Back-to-back three-word run with a matching golden value.
    exp_v[0] = 5'b00001;
    send(0, 5'b00001);  check("lit_sig1", 0, int'(sig_v[0]), 5'b00001);
    send(0, 5'b10000);  check("lit_sig2", 0, int'(sig_v[0]), 5'b10010);
    check("lit_not_done", 0, int'(done_v[0]), 0);
    send(0, 5'b00000);  check("lit_sig3", 0, int'(sig_v[0]), 5'b00001);
    check("lit_done", 0, int'(done_v[0]), 1);
    check("lit_pass1", 0, int'(pass_v[0]), 1);
    check("lit_cnt3", 0, cnt_v[0], 3);

    // Restart from DONE, ignored start mid-run, gaps, mismatching golden value.
    exp_v[0] = 5'b00010;
    pulse_start(0);
    check("lit_rs_busy", 0, int'(busy_v[0]), 1);
    check("lit_rs_done", 0, int'(done_v[0]), 0);
    check("lit_rs_sig", 0, int'(sig_v[0]), 0);
    check("lit_rs_cnt", 0, cnt_v[0], 0);
    send(0, 5'b00001);
    pulse_start(0);
    check("lit_mid_cnt", 0, cnt_v[0], 1);
    repeat (4) step();
    send(0, 5'b10000);
    repeat (4) step();
    check("lit_gap_busy", 0, int'(busy_v[0]), 1);
    send(0, 5'b00000);
    check("lit_gap_sig", 0, int'(sig_v[0]), 5'b00001);
    check("lit_gap_cnt", 0, cnt_v[0], 3);
    check("lit_pass0", 0, int'(pass_v[0]), 0);

    // Responses offered in DONE change nothing.
    repeat (10) begin
      valid_v[0] = 1'b1; data_v[0] = 5'($urandom);
      step();
    end
    valid_v[0] = 1'b0;
    check("lit_hold_sig", 0, int'(sig_v[0]), 5'b00001);
    check("lit_hold_cnt", 0, cnt_v[0], 3);
    check("lit_hold_pass", 0, int'(pass_v[0]), 0);

    // Random short runs; golden is either the true signature or random.
    repeat (8) begin
      logic [4:0] w [3];
      rexp = SEED;
      for (int i = 0; i < 3; i++) begin
        w[i] = 5'($urandom);
        rexp = fold(rexp, w[i]);
      end
      exp_v[0] = ($urandom_range(0, 1) == 1) ? rexp : 5'($urandom);
      pulse_start(0);
      for (int i = 0; i < 3; i++) begin
        repeat ($urandom_range(0, 2)) step();
        if ($urandom_range(0, 3) == 0) start_v[0] = 1'b1;
        send(0, w[i]);
        start_v[0] = 1'b0;
      end
      check("rnd_sig", 0, int'(sig_v[0]), int'(rexp));
      check("rnd_pass", 0, int'(pass_v[0]), int'(rexp == exp_v[0]));
    end

    // Exhaustive fault-free run captures the golden G, then a stuck-at-0 carry.
    g = SEED;
    gf = SEED;
    for (int t = 0; t < 256; t++) begin
      g  = fold(g,  adder_resp(t, 1'b0));
      gf = fold(gf, adder_resp(t, 1'b1));
    end
    exp_v[1] = g;
    run_exhaustive(1'b0);
    check("gold_done", 1, int'(done_v[1]), 1);
    check("gold_sig", 1, int'(sig_v[1]), int'(g));
    check("gold_pass", 1, int'(pass_v[1]), 1);
    check("gold_cnt", 1, cnt_v[1], 256);
    run_exhaustive(1'b1);
    check("fault_done", 1, int'(done_v[1]), 1);
    check("fault_sig", 1, int'(sig_v[1]), int'(gf));
    check("fault_pass", 1, int'(pass_v[1]), int'(gf == g));
    check("fault_cnt", 1, cnt_v[1], 256);

    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
